reorder_buffer: RTL and testbench

In-order commit buffer for the 8-bit out-of-order core; sits directly downstream of the memory stage and upstream of the register file. Dispatch allocates an entry per instruction in program order. Results return from the memory stage tagged with their entry index, possibly out of order. The buffer retires completed entries strictly in order, one per cycle, driving the register-file write port.

---
 rtl/reorder_buffer_if.sv | 45 ++++
 rtl/reorder_buffer.sv | 101 ++++++++++
 tb/tb_reorder_buffer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Handshake and result bus between dispatch / memory stage / register file
// and the in-order commit buffer.
//
// Valid/ready semantics: an allocation transfers on a rising edge where
// alloc_valid && alloc_ready are both high (and flush is low); alloc_tag is
// the index granted by that transfer. wb_valid and commit_valid have no
// backpressure: they are single-cycle qualifiers for their data fields.
interface reorder_buffer_if #(
    parameter int  DEPTH  = 4,
    parameter int  DATA_W = 8,
    parameter int  REG_W  = 3,
    localparam int TAG_W  = $clog2(DEPTH)
);
    logic              flush;
    logic              alloc_valid;
    logic              alloc_has_dest;
    logic [REG_W-1:0]  alloc_rd;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_data;
    logic              commit_valid;
    logic              rf_we;
    logic [REG_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [TAG_W:0]    count;
    logic              empty;

    // Pipeline side: drives dispatch, writeback and flush.
    modport master (
        output flush, alloc_valid, alloc_has_dest, alloc_rd,
        output wb_valid, wb_tag, wb_data,
        input  alloc_ready, alloc_tag, commit_valid,
        input  rf_we, rf_waddr, rf_wdata, count, empty
    );

    // Buffer side.
    modport slave (
        input  flush, alloc_valid, alloc_has_dest, alloc_rd,
        input  wb_valid, wb_tag, wb_data,
        output alloc_ready, alloc_tag, commit_valid,
        output rf_we, rf_waddr, rf_wdata, count, empty
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order commit buffer: entries are allocated in program order, completed
// out of order by tagged writebacks, and retired strictly in order at one
// entry per cycle onto the register-file write port.
module reorder_buffer #(
    parameter int  DEPTH  = 4,
    parameter int  DATA_W = 8,
    parameter int  REG_W  = 3,
    localparam int TAG_W  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    reorder_buffer_if.slave bus
);
    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  done_q;
    logic [DEPTH-1:0]  has_dest_q;
    logic [REG_W-1:0]  rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [TAG_W-1:0]  head_q;
    logic [TAG_W-1:0]  tail_q;
    logic [TAG_W:0]    count_q;

    logic head_ready;
    logic alloc_fire;
    logic commit_fire;
    logic wb_accept;

    // Event decode; flush suppresses every state-changing event this cycle.
    always_comb begin
        head_ready  = valid_q[head_q] && done_q[head_q];
        alloc_fire  = bus.alloc_valid && (count_q != FULL_COUNT) && !bus.flush;
        commit_fire = head_ready && !bus.flush;
        wb_accept   = bus.wb_valid && valid_q[bus.wb_tag] && !done_q[bus.wb_tag]
                      && !bus.flush;
    end

    // Outputs decoded from registered state; payload is zeroed when idle.
    assign bus.alloc_ready  = (count_q != FULL_COUNT);
    assign bus.alloc_tag    = tail_q;
    assign bus.commit_valid = head_ready;
    assign bus.rf_we        = head_ready && has_dest_q[head_q] && !bus.flush;
    assign bus.rf_waddr     = head_ready ? rd_q[head_q]   : '0;
    assign bus.rf_wdata     = head_ready ? data_q[head_q] : '0;
    assign bus.count        = count_q;
    assign bus.empty        = (count_q == '0);

    // Control state: valid/done bits, pointers and occupancy count.
    // Pointers are TAG_W wide, so DEPTH being a power of two gives free wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // Indices never collide: the tail entry is invalid whenever an
            // allocate fires, and a done head ignores writebacks.
            if (wb_accept) begin
                done_q[bus.wb_tag] <= 1'b1;
            end
            if (commit_fire) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (alloc_fire) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                tail_q          <= tail_q + 1'b1;
            end
            count_q <= count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_fire);
        end
    end

    // Payload storage: destination info at allocate, result at writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            has_dest_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (alloc_fire) begin
                has_dest_q[tail_q] <= bus.alloc_has_dest;
                rd_q[tail_q]       <= bus.alloc_rd;
            end
            if (wb_accept) begin
                data_q[bus.wb_tag] <= bus.wb_data;
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed vector table for the ordering, full,
// wrap and flush corners, randomized traffic against a reference model with
// an expected-commit queue, and an asynchronous reset in mid-operation.
module tb_reorder_buffer;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;
    localparam int REG_W  = 3;
    localparam int TAG_W  = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reorder_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) bus ();

    reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    logic [11:0] exp_q[$];   // {has_dest, rd[2:0], data[7:0]} in commit order

    typedef struct {
        logic       fl, av, hd;
        logic [2:0] rd;
        logic       wv;
        logic [1:0] wt;
        logic [7:0] wd;
        logic [2:0] e_cnt;
        logic [1:0] e_tag;
        logic       e_rdy, e_cv, e_we;
        logic [2:0] e_wa;
        logic [7:0] e_wd;
    } vec_t;
    vec_t vecs[$];

    // Reference model state for the random phase.
    logic [3:0] m_valid, m_done;
    logic [7:0] m_plan [4];
    int m_head, m_tail, m_count;
    logic       r_fl, r_av, r_hd, r_wv, r_acc, r_cv;
    logic [2:0] r_rd;
    logic [1:0] r_wt;
    logic [7:0] r_wd;
    logic [1:0] pend [4];
    int         n_pend;
    logic [11:0] e;

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic av, input logic hd, input logic [2:0] rd,
                         input logic wv, input logic [1:0] wt, input logic [7:0] wd);
        bus.flush          = fl;
        bus.alloc_valid    = av;
        bus.alloc_has_dest = hd;
        bus.alloc_rd       = rd;
        bus.wb_valid       = wv;
        bus.wb_tag         = wt;
        bus.wb_data        = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string p, input logic [2:0] cnt, input logic [1:0] tag,
                              input logic rdy, input logic cv, input logic we,
                              input logic [2:0] wa, input logic [7:0] wd);
        check({p, "_count"}, 32'(bus.count), 32'(cnt));
        check({p, "_empty"}, 32'(bus.empty), 32'(cnt == 3'd0));
        check({p, "_alloc_tag"}, 32'(bus.alloc_tag), 32'(tag));
        check({p, "_alloc_ready"}, 32'(bus.alloc_ready), 32'(rdy));
        check({p, "_commit_valid"}, 32'(bus.commit_valid), 32'(cv));
        check({p, "_rf_we"}, 32'(bus.rf_we), 32'(we));
        check({p, "_rf_waddr"}, 32'(bus.rf_waddr), 32'(wa));
        check({p, "_rf_wdata"}, 32'(bus.rf_wdata), 32'(wd));
    endtask

    task automatic add(input logic fl, input logic av, input logic hd, input logic [2:0] rd,
                       input logic wv, input logic [1:0] wt, input logic [7:0] wd,
                       input logic [2:0] c, input logic [1:0] t, input logic r,
                       input logic cv, input logic we, input logic [2:0] wa, input logic [7:0] d);
        vec_t v;
        v.fl = fl; v.av = av; v.hd = hd; v.rd = rd; v.wv = wv; v.wt = wt; v.wd = wd;
        v.e_cnt = c; v.e_tag = t; v.e_rdy = r; v.e_cv = cv; v.e_we = we; v.e_wa = wa; v.e_wd = d;
        vecs.push_back(v);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Each row: inputs for one cycle | outputs expected during that cycle.
        //  fl av hd rd  wv wt wd     | cnt tag rdy cv we wa wd
        add(0, 1, 1, 1, 0, 0, 8'h00,  0, 0, 1, 0, 0, 0, 8'h00);
        add(0, 1, 1, 2, 0, 0, 8'h00,  1, 1, 1, 0, 0, 0, 8'h00);
        add(0, 1, 1, 3, 0, 0, 8'h00,  2, 2, 1, 0, 0, 0, 8'h00);
        add(0, 1, 1, 4, 0, 0, 8'h00,  3, 3, 1, 0, 0, 0, 8'h00);
        add(0, 1, 1, 5, 1, 2, 8'h22,  4, 0, 0, 0, 0, 0, 8'h00); // fifth alloc ignored
        add(0, 0, 0, 0, 1, 2, 8'h99,  4, 0, 0, 0, 0, 0, 8'h00); // duplicate wb ignored
        add(0, 0, 0, 0, 1, 0, 8'h00,  4, 0, 0, 0, 0, 0, 8'h00);
        add(0, 0, 0, 0, 1, 1, 8'h11,  4, 0, 0, 1, 1, 1, 8'h00); // rd1 retires
        add(0, 0, 0, 0, 0, 0, 8'h00,  3, 0, 1, 1, 1, 2, 8'h11); // rd2
        add(0, 0, 0, 0, 0, 0, 8'h00,  2, 0, 1, 1, 1, 3, 8'h22); // rd3, not 0x99
        add(0, 0, 0, 0, 1, 3, 8'h44,  1, 0, 1, 0, 0, 0, 8'h00); // tag3 was pending
        add(0, 1, 0, 6, 0, 0, 8'h00,  1, 0, 1, 1, 1, 4, 8'h44); // alloc + commit
        add(0, 0, 0, 0, 1, 0, 8'h55,  1, 1, 1, 0, 0, 0, 8'h00);
        add(0, 0, 0, 0, 0, 0, 8'h00,  1, 1, 1, 1, 0, 6, 8'h55); // no-dest retire
        add(0, 0, 0, 0, 0, 0, 8'h00,  0, 1, 1, 0, 0, 0, 8'h00);
        add(0, 1, 1, 1, 0, 0, 8'h00,  0, 1, 1, 0, 0, 0, 8'h00);
        add(0, 1, 1, 2, 0, 0, 8'h00,  1, 2, 1, 0, 0, 0, 8'h00);
        add(0, 1, 1, 3, 0, 0, 8'h00,  2, 3, 1, 0, 0, 0, 8'h00);
        add(0, 1, 1, 4, 1, 1, 8'hA1,  3, 0, 1, 0, 0, 0, 8'h00); // tail wraps
        add(0, 1, 1, 5, 0, 0, 8'h00,  4, 1, 0, 1, 1, 1, 8'hA1); // commit frees no slot now
        add(0, 1, 1, 7, 0, 0, 8'h00,  3, 1, 1, 0, 0, 0, 8'h00); // alloc gets old head 1
        add(0, 0, 0, 0, 1, 2, 8'hB2,  4, 2, 0, 0, 0, 0, 8'h00);
        add(1, 1, 1, 1, 1, 3, 8'h33,  4, 2, 0, 1, 0, 2, 8'hB2); // flush gates rf_we
        add(0, 0, 0, 0, 1, 0, 8'hC0,  0, 0, 1, 0, 0, 0, 8'h00); // stale wb
        add(0, 0, 0, 0, 0, 0, 8'h00,  0, 0, 1, 0, 0, 0, 8'h00);
        add(0, 1, 1, 2, 0, 0, 8'h00,  0, 0, 1, 0, 0, 0, 8'h00);
        add(0, 0, 0, 0, 1, 3, 8'h33,  1, 1, 1, 0, 0, 0, 8'h00); // wb to invalid tag
        add(0, 0, 0, 0, 0, 0, 8'h00,  1, 1, 1, 0, 0, 0, 8'h00);

        // Reset values while reset is held.
        drive(0, 0, 0, 0, 0, 0, 8'h00);
        rst_n = 1'b0;
        step();
        step();
        check_outs("reset", 0, 0, 1, 0, 0, 0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Directed table.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].fl, vecs[i].av, vecs[i].hd, vecs[i].rd,
                  vecs[i].wv, vecs[i].wt, vecs[i].wd);
            @(negedge clk);
            check_outs($sformatf("row%0d", i), vecs[i].e_cnt, vecs[i].e_tag, vecs[i].e_rdy,
                       vecs[i].e_cv, vecs[i].e_we, vecs[i].e_wa, vecs[i].e_wd);
            step();
        end

        // Random traffic against the reference model, starting from a flush.
        drive(1, 0, 0, 0, 0, 0, 8'h00);
        step();
        m_valid = '0; m_done = '0; m_head = 0; m_tail = 0; m_count = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            r_fl = ($urandom_range(0, 39) == 0);
            r_av = ($urandom_range(0, 9) < 6);
            r_hd = 1'($urandom_range(0, 1));
            r_rd = 3'($urandom_range(0, 7));
            n_pend = 0;
            for (int k = 0; k < DEPTH; k++) begin
                if (m_valid[k] && !m_done[k]) begin
                    pend[n_pend] = 2'(k);
                    n_pend++;
                end
            end
            r_wv = 1'b0; r_wt = '0; r_wd = '0;
            if (n_pend > 0 && $urandom_range(0, 9) < 6) begin
                r_wv = 1'b1;
                r_wt = pend[$urandom_range(0, n_pend - 1)];
                r_wd = m_plan[r_wt];
            end else if ($urandom_range(0, 4) == 0) begin
                r_wv = 1'b1;
                r_wt = 2'($urandom_range(0, 3));
                r_wd = (m_valid[r_wt] && !m_done[r_wt]) ? m_plan[r_wt] : 8'($urandom_range(0, 255));
            end
            drive(r_fl, r_av, r_hd, r_rd, r_wv, r_wt, r_wd);
            @(negedge clk);

            r_cv  = m_valid[m_head] && m_done[m_head];
            r_acc = r_av && (m_count != DEPTH);
            check("rand_count", 32'(bus.count), 32'(m_count));
            check("rand_alloc_tag", 32'(bus.alloc_tag), 32'(m_tail));
            check("rand_alloc_ready", 32'(bus.alloc_ready), 32'(m_count != DEPTH));
            check("rand_commit_valid", 32'(bus.commit_valid), 32'(r_cv));

            // Scoreboard: every retire must match the oldest outstanding alloc.
            if (bus.commit_valid && !r_fl) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_commit", 32'(bus.commit_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_rf_we", 32'(bus.rf_we), 32'(e[11]));
                    check("sb_rf_waddr", 32'(bus.rf_waddr), 32'(e[10:8]));
                    check("sb_rf_wdata", 32'(bus.rf_wdata), 32'(e[7:0]));
                end
            end else if (r_fl) begin
                check("rand_flush_we", 32'(bus.rf_we), 32'd0);
            end

            // Model update for the coming edge.
            if (r_fl) begin
                m_valid = '0; m_done = '0; m_head = 0; m_tail = 0; m_count = 0;
                exp_q.delete();
            end else begin
                if (r_wv && m_valid[r_wt] && !m_done[r_wt]) m_done[r_wt] = 1'b1;
                if (r_cv) begin
                    m_valid[m_head] = 1'b0;
                    m_head = (m_head + 1) % DEPTH;
                    m_count--;
                end
                if (r_acc) begin
                    m_valid[m_tail] = 1'b1;
                    m_done[m_tail]  = 1'b0;
                    m_plan[m_tail]  = 8'($urandom_range(0, 255));
                    exp_q.push_back({r_hd, r_rd, m_plan[m_tail]});
                    m_tail = (m_tail + 1) % DEPTH;
                    m_count++;
                end
            end
            step();
        end

        // Asynchronous reset between edges with entries pending.
        drive(1, 0, 0, 0, 0, 0, 8'h00);
        step();
        drive(0, 1, 1, 5, 0, 0, 8'h00);
        step();
        drive(0, 1, 1, 6, 1, 0, 8'h5A);
        step();
        drive(0, 0, 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        check_outs("pre_async", 2, 2, 1, 1, 1, 5, 8'h5A);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_reset", 0, 0, 1, 0, 0, 0, 8'h00);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_outs("post_reset", 0, 0, 1, 0, 0, 0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
